// File: rtl/move_bus_responder.sv
// Strobe-driven datapath responder: registers R0..R3, output port P0 and synchronized input P1
// share one internal bus; strobe-protocol violations are flagged and good transfers counted.
module move_bus_responder #(
  parameter int WIDTH   = 8,
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               R0_write,
  input  logic               R1_write,
  input  logic               R2_write,
  input  logic               R3_write,
  input  logic               P0_write,
  input  logic               R0_read,
  input  logic               R1_read,
  input  logic               R2_read,
  input  logic               R3_read,
  input  logic               P0_read,
  input  logic               P1_read,
  input  logic [WIDTH-1:0]   p1_in,
  input  logic               clr_err,
  output logic [WIDTH-1:0]   bus,
  output logic [WIDTH-1:0]   p0_out,
  output logic               p0_update,
  output logic [WIDTH-1:0]   r0_q,
  output logic [WIDTH-1:0]   r1_q,
  output logic [WIDTH-1:0]   r2_q,
  output logic [WIDTH-1:0]   r3_q,
  output logic [COUNT_W-1:0] xfer_count,
  output logic               contention_err,
  output logic               orphan_err
);

  logic [WIDTH-1:0] p1_meta;
  logic [WIDTH-1:0] p1_sync;
  logic [2:0]       nreads;
  logic             any_write;
  logic             valid_xfer;
  logic             contention;
  logic             orphan;

  assign nreads = 3'(R0_read) + 3'(R1_read) + 3'(R2_read)
                + 3'(R3_read) + 3'(P0_read) + 3'(P1_read);

  assign any_write  = R0_write | R1_write | R2_write | R3_write | P0_write;
  assign valid_xfer = (nreads == 3'd1) && any_write;
  assign contention = (nreads > 3'd1);
  assign orphan     = (nreads == 3'd0) && any_write;

  // NOTE: the default assignment first guarantees bus is driven on every path, so no latch is inferred.
  always_comb begin
    bus = '0;
    if (nreads == 3'd1) begin
      if      (R0_read) bus = r0_q;
      else if (R1_read) bus = r1_q;
      else if (R2_read) bus = r2_q;
      else if (R3_read) bus = r3_q;
      else if (P0_read) bus = p0_out;
      else              bus = p1_sync;
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r0_q           <= '0;
      r1_q           <= '0;
      r2_q           <= '0;
      r3_q           <= '0;
      p0_out         <= '0;
      p0_update      <= 1'b0;
      p1_meta        <= '0;
      p1_sync        <= '0;
      xfer_count     <= '0;
      contention_err <= 1'b0;
      orphan_err     <= 1'b0;
    end else begin
      p1_meta <= p1_in;
      p1_sync <= p1_meta;
      if (valid_xfer) begin
        if (R0_write) r0_q   <= bus;
        if (R1_write) r1_q   <= bus;
        if (R2_write) r2_q   <= bus;
        if (R3_write) r3_q   <= bus;
        if (P0_write) p0_out <= bus;
        xfer_count <= xfer_count + COUNT_W'(1);
      end
      p0_update <= valid_xfer & P0_write;
      // A violation in the same cycle as clr_err leaves its flag set.
      contention_err <= (contention_err & ~clr_err) | contention;
      orphan_err     <= (orphan_err & ~clr_err) | orphan;
    end
  end

endmodule

// File: tb/tb_move_bus_responder.sv
// Self-checking bench for move_bus_responder: directed scenarios plus randomized strobes,
// all compared against a transaction-level model of the register file and flags.
module tb_move_bus_responder;

  localparam int WIDTH   = 8;
  localparam int COUNT_W = 8;

  logic               clk;
  logic               reset;
  logic [5:0]         rd;   // R0,R1,R2,R3,P0,P1
  logic [4:0]         wr;   // R0,R1,R2,R3,P0
  logic [WIDTH-1:0]   p1_in;
  logic               clr_err;
  logic [WIDTH-1:0]   bus, p0_out, r0_q, r1_q, r2_q, r3_q;
  logic               p0_update, contention_err, orphan_err;
  logic [COUNT_W-1:0] xfer_count;

  int checks   = 0;
  int failures = 0;

  // Model state: index 0..3 = R0..R3, 4 = P0.
  int unsigned  m_reg [5];
  int unsigned  m_count;
  bit           m_upd, m_cont, m_orph;
  int unsigned  p1_hist[$];   // oldest entry is what P1_read delivers

  move_bus_responder #(.WIDTH(WIDTH), .COUNT_W(COUNT_W)) dut (
    .clk(clk), .reset(reset),
    .R0_write(wr[0]), .R1_write(wr[1]), .R2_write(wr[2]), .R3_write(wr[3]), .P0_write(wr[4]),
    .R0_read(rd[0]), .R1_read(rd[1]), .R2_read(rd[2]), .R3_read(rd[3]),
    .P0_read(rd[4]), .P1_read(rd[5]),
    .p1_in(p1_in), .clr_err(clr_err),
    .bus(bus), .p0_out(p0_out), .p0_update(p0_update),
    .r0_q(r0_q), .r1_q(r1_q), .r2_q(r2_q), .r3_q(r3_q),
    .xfer_count(xfer_count), .contention_err(contention_err), .orphan_err(orphan_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned model_bus();
    if ($countones(rd) != 1) return 0;
    for (int i = 0; i < 5; i++) if (rd[i]) return m_reg[i];
    return p1_hist[0];
  endfunction

  // One clock cycle: drive inputs, check the combinational bus, clock, update the model, check state.
  task automatic cycle(input logic [5:0] r, input logic [4:0] w, input logic [7:0] p1,
                       input logic clr, input logic rst);
    int unsigned b;
    int n;
    rd = r; wr = w; p1_in = p1; clr_err = clr; reset = rst;
    #2;
    b = model_bus();
    if (!rst) check("bus", 32'(bus), b);
    @(posedge clk);
    n = $countones(r);
    if (rst) begin
      foreach (m_reg[i]) m_reg[i] = 0;
      m_count = 0; m_upd = 0; m_cont = 0; m_orph = 0;
      p1_hist = {0, 0};
    end else begin
      m_upd = 0;
      if (n == 1 && w != 0) begin
        for (int i = 0; i < 5; i++) if (w[i]) m_reg[i] = b;
        m_count = (m_count + 1) % (1 << COUNT_W);
        m_upd   = w[4];
      end
      m_cont = (m_cont && !clr) || (n > 1);
      m_orph = (m_orph && !clr) || (n == 0 && w != 0);
      p1_hist.push_back(32'(p1));
      void'(p1_hist.pop_front());
    end
    #1;
    check("r0_q", 32'(r0_q), m_reg[0]);
    check("r1_q", 32'(r1_q), m_reg[1]);
    check("r2_q", 32'(r2_q), m_reg[2]);
    check("r3_q", 32'(r3_q), m_reg[3]);
    check("p0_out", 32'(p0_out), m_reg[4]);
    check("p0_update", 32'(p0_update), 32'(m_upd));
    check("xfer_count", 32'(xfer_count), m_count);
    check("contention_err", 32'(contention_err), 32'(m_cont));
    check("orphan_err", 32'(orphan_err), 32'(m_orph));
  endtask

  initial begin
    logic [5:0] r;
    logic [4:0] w;
    rd = '0; wr = '0; p1_in = '0; clr_err = 1'b0; reset = 1'b1;
    cycle(6'h00, 5'h00, 8'h00, 1'b0, 1'b1);
    check("reset_count", 32'(xfer_count), 0);
    check("reset_p0", 32'(p0_out), 0);

    // P1 before the synchronizer settles delivers the old (zero) value.
    cycle(6'h20, 5'h01, 8'hA5, 1'b0, 1'b0);
    check("p1_unsettled", 32'(r0_q), 32'h00);
    cycle(6'h00, 5'h00, 8'hA5, 1'b0, 1'b1);
    cycle(6'h00, 5'h00, 8'hA5, 1'b0, 1'b0);
    cycle(6'h00, 5'h00, 8'hA5, 1'b0, 1'b0);
    cycle(6'h20, 5'h01, 8'hA5, 1'b0, 1'b0);
    check("p1_settled", 32'(r0_q), 32'hA5);
    check("p1_count", 32'(xfer_count), 1);

    // Broadcast R0 -> R1, R3, P0.
    cycle(6'h00, 5'h00, 8'h3C, 1'b0, 1'b0);
    cycle(6'h00, 5'h00, 8'h3C, 1'b0, 1'b0);
    cycle(6'h20, 5'h01, 8'h3C, 1'b0, 1'b0);
    check("r0_3c", 32'(r0_q), 32'h3C);
    cycle(6'h01, 5'h1A, 8'h00, 1'b0, 1'b0);
    check("bcast_r1", 32'(r1_q), 32'h3C);
    check("bcast_r3", 32'(r3_q), 32'h3C);
    check("bcast_p0", 32'(p0_out), 32'h3C);
    check("bcast_upd", 32'(p0_update), 1);
    check("bcast_count", 32'(xfer_count), 3);
    cycle(6'h00, 5'h00, 8'h00, 1'b0, 1'b0);
    check("upd_pulse_end", 32'(p0_update), 0);

    // Contention, then clear.
    cycle(6'h06, 5'h01, 8'h00, 1'b0, 1'b0);
    check("cont_r0_hold", 32'(r0_q), 32'h3C);
    check("cont_flag", 32'(contention_err), 1);
    check("cont_count", 32'(xfer_count), 3);
    cycle(6'h00, 5'h00, 8'h00, 1'b1, 1'b0);
    check("cont_clr", 32'(contention_err), 0);

    // Orphan write; repeat it alongside clr_err so set wins.
    cycle(6'h00, 5'h04, 8'h00, 1'b0, 1'b0);
    check("orph_flag", 32'(orphan_err), 1);
    check("orph_r2_hold", 32'(r2_q), 0);
    cycle(6'h00, 5'h04, 8'h00, 1'b1, 1'b0);
    check("orph_set_wins", 32'(orphan_err), 1);
    cycle(6'h00, 5'h00, 8'h00, 1'b1, 1'b0);
    check("orph_clr", 32'(orphan_err), 0);

    // Counter wrap: 256 transfers from a fresh reset.
    cycle(6'h00, 5'h00, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 256; i++) cycle(6'h01, 5'h02, 8'h00, 1'b0, 1'b0);
    check("count_wrap", 32'(xfer_count), 0);

    // Reset wins over a strobe cycle.
    cycle(6'h00, 5'h00, 8'h77, 1'b0, 1'b0);
    cycle(6'h00, 5'h00, 8'h77, 1'b0, 1'b0);
    cycle(6'h20, 5'h10, 8'h77, 1'b0, 1'b0);
    check("p0_77", 32'(p0_out), 32'h77);
    cycle(6'h08, 5'h10, 8'h77, 1'b0, 1'b1);
    check("rst_p0", 32'(p0_out), 0);
    check("rst_upd", 32'(p0_update), 0);
    check("rst_count", 32'(xfer_count), 0);

    // Randomized strobes, mostly single-source transfers.
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 9))
        0:       r = 6'h00;
        1:       r = 6'(1 << $urandom_range(0, 5)) | 6'(1 << $urandom_range(0, 5));
        default: r = 6'(1 << $urandom_range(0, 5));
      endcase
      w = ($urandom_range(0, 4) == 0) ? 5'h00 : 5'($urandom_range(0, 31));
      cycle(r, w, 8'($urandom), ($urandom_range(0, 7) == 0), ($urandom_range(0, 63) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/move_bus_responder.md
Name: move_bus_responder

Overview:
- Datapath responder for the move-control FSM's strobe interface.
- Holds general registers R0..R3 and output port P0, and samples input port P1.
- Routes the single selected read source onto an internal bus and loads that bus into every write-strobed destination on the clock edge.
- Flags strobe-protocol violations and counts completed transfers for bring-up and debug.

Parameters:
WIDTH, 8, data width of registers, ports and bus
COUNT_W, 8, width of transfer counter

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high; clears all state on the next rising edge of clk
R0_write  input  1  load bus into R0 this cycle
R1_write  input  1  load bus into R1 this cycle
R2_write  input  1  load bus into R2 this cycle
R3_write  input  1  load bus into R3 this cycle
P0_write  input  1  load bus into P0 output register this cycle
R0_read  input  1  drive R0 onto bus
R1_read  input  1  drive R1 onto bus
R2_read  input  1  drive R2 onto bus
R3_read  input  1  drive R3 onto bus
P0_read  input  1  drive P0 register onto bus
P1_read  input  1  drive synchronized P1 input onto bus
p1_in  input  WIDTH  asynchronous external input port
clr_err  input  1  synchronous clear of error flags
bus  output  WIDTH  current bus value (combinational)
p0_out  output  WIDTH  P0 register contents
p0_update  output  1  one-cycle pulse: P0 was loaded on the previous edge
r0_q, r1_q, r2_q, r3_q  output  WIDTH  register contents (debug/observation)
xfer_count  output  COUNT_W  number of valid transfers, wraps
contention_err  output  1  sticky: more than one read strobe asserted in one cycle
orphan_err  output  1  sticky: a write strobe asserted with no read strobe

Behaviour:
- Reset (synchronous): R0..R3, P0, both P1 sync stages, xfer_count and both error flags go to 0; p0_update goes to 0. Reset overrides all strobes in the same cycle.
- Read decode, combinational:
  - nreads = count of the six read strobes.
  - nreads==1: bus = selected source.
  - nreads==0 or nreads>1: bus = 0.
- P1 path: p1_in passes through a 2-flop synchronizer. P1_read selects stage-2 output, so a change on p1_in is visible on bus 2 edges later.
- Valid transfer cycle: nreads==1 and at least one write strobe.
  - Every asserted write destination loads bus on that edge; multiple writes are a legal broadcast.
  - Self-move (e.g. R2_read with R2_write) is legal; the value is unchanged.
  - xfer_count increments by 1 and wraps from 2^COUNT_W-1 to 0.
- Read-only cycle (nreads==1, no write): no state change and no count. bus still shows the source.
- Contention (nreads>1):
  - All writes in that cycle are suppressed; registers hold.
  - contention_err sets on the edge. No count.
- Orphan (nreads==0 with any write):
  - Writes are suppressed.
  - orphan_err sets on the edge. No count.
- Idle (no strobes): hold all state.
- p0_update is registered: it is high for exactly the one cycle after an edge on which P0 loaded, and p0_out is updated on that same edge. Back-to-back P0 writes hold p0_update high continuously.
- clr_err clears both flags on the edge. If a new violation occurs in the same cycle as clr_err, the corresponding flag is set (set wins).
- Strobes are level signals sampled every edge; a strobe held N cycles performs N transfers.
- The responder imposes no handshake. The controller's done is not an input here; the transfer completes on the edge where strobes are high (zero-wait).
- Reset during a strobe cycle: reset wins, no load, no count.

Test Plan:
- Reset, then P1_read with R0_write, with p1_in=8'hA5 held stable for 3 cycles -> r0_q=8'hA5 and xfer_count=1; the same stimulus before sync settles loads 8'h00.
- Single edge with R0_read + R1_write + R3_write + P0_write, R0=8'h3C -> r1_q=r3_q=p0_out=8'h3C, p0_update high exactly one cycle, xfer_count +1.
- Single edge with R1_read + R2_read + R0_write -> bus=0, r0_q unchanged, contention_err=1, xfer_count unchanged; then clr_err -> contention_err=0.
- Single edge with R2_write only -> r2_q unchanged, orphan_err=1; same cycle as clr_err -> flag stays 1.
- 256 consecutive cycles of R0_read + R1_write with COUNT_W=8 -> xfer_count wraps to 0.
- Reset asserted in the same cycle as R3_read + P0_write (P0=8'h77 beforehand) -> p0_out=0, p0_update=0, xfer_count=0.
